ft245_fifo_responder: RTL and testbench

- Synthesizable model of the FT2232H side of the async 245-style FIFO bus. It responds to the FPGA-side FIFO master: it drives nRXF/nTXE, serves reads on nRD and captures writes on nWR.
- Host side is a pair of simple FIFO ports. The bench or a USB stand-in pushes bytes destined for the FPGA and pops bytes the FPGA wrote.
- Used for loopback bring-up and for closed-loop simulation of the audio interface without hardware.

---
 rtl/ft245_fifo_responder_if.sv | 22 ++
 rtl/ft245_fifo_responder.sv | 203 ++++++++++++++++++++
 tb/tb_ft245_fifo_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft245_fifo_responder_if.sv
// FT245 async FIFO bus handshake signals between the FPGA-side master and
// the FT2232H-side responder. The 8-bit data bus stays a plain inout port.
interface ft245_fifo_responder_if;
    logic nRD_i;
    logic nWR_i;
    logic nRXF_o;
    logic nTXE_o;

    modport slave (
        input  nRD_i,
        input  nWR_i,
        output nRXF_o,
        output nTXE_o
    );

    modport master (
        output nRD_i,
        output nWR_i,
        input  nRXF_o,
        input  nTXE_o
    );
endinterface

// File: rtl/ft245_fifo_responder.sv
// FT2232H-side responder for the async 245-style FIFO bus.
// RX FIFO: host -> FPGA (served on nRD). TX FIFO: FPGA -> host (captured on nWR).
// Optional macro FT245_RESP_LOOPBACK_EN: every captured write byte is also
// pushed into the RX FIFO and host_push_i is ignored.
module ft245_fifo_responder #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RXF_HOLD = 2,
    parameter int unsigned TXE_HOLD = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    ft245_fifo_responder_if.slave    bus,
    inout  wire  [7:0]               data_io,
    input  logic                     host_push_i,
    input  logic [7:0]               host_data_i,
    output logic                     host_full_o,
    input  logic                     host_pop_i,
    output logic [7:0]               host_data_o,
    output logic                     host_empty_o,
    output logic [$clog2(DEPTH):0]   rx_count_o,
    output logic [$clog2(DEPTH):0]   tx_count_o,
    output logic                     overflow_o,
    output logic                     proto_err_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned RHW = (RXF_HOLD < 1) ? 1 : $clog2(RXF_HOLD + 1);
    localparam int unsigned THW = (TXE_HOLD < 1) ? 1 : $clog2(TXE_HOLD + 1);

    typedef enum logic {
        RD_IDLE,
        RD_ACTIVE
    } rd_state_t;

    rd_state_t        rd_state;
    logic             nrd_q;
    logic             nwr_q;
    logic             nrxf_q;
    logic             ntxe_q;
    logic             overflow_q;
    logic             proto_err_q;
    logic [RHW-1:0]   rxf_hold;
    logic [THW-1:0]   txe_hold;

    logic [7:0]       rx_mem [DEPTH];
    logic [AW-1:0]    rx_wr_ptr;
    logic [AW-1:0]    rx_rd_ptr;
    logic [CW-1:0]    rx_count;

    logic [7:0]       tx_mem [DEPTH];
    logic [AW-1:0]    tx_wr_ptr;
    logic [AW-1:0]    tx_rd_ptr;
    logic [CW-1:0]    tx_count;

    logic             rd_fall;
    logic             rd_rise;
    logic             wr_fall;
    logic             wr_rise;
    logic             both_low;
    logic             rx_empty;
    logic             rx_full;
    logic             tx_empty;
    logic             tx_full;
    logic             wr_cap;
    logic             rx_src;
    logic [7:0]       rx_src_data;
    logic             rx_push;
    logic             rx_pop;
    logic             tx_push;
    logic             tx_pop;
    logic             overflow_d;
    logic             proto_err_d;
    logic             rd_drive;

`ifdef FT245_RESP_LOOPBACK_EN
    logic             unused_host;
    assign unused_host = ^{host_push_i, host_data_i};
`endif

    // Strobe edge detection, FIFO status and per-cycle transfer decisions.
    always_comb begin
        rd_fall     = ~bus.nRD_i & nrd_q;
        rd_rise     = bus.nRD_i & ~nrd_q;
        wr_fall     = ~bus.nWR_i & nwr_q;
        wr_rise     = bus.nWR_i & ~nwr_q;
        both_low    = ~bus.nRD_i & ~bus.nWR_i;

        rx_empty    = (rx_count == '0);
        rx_full     = (rx_count == CW'(DEPTH));
        tx_empty    = (tx_count == '0);
        tx_full     = (tx_count == CW'(DEPTH));

        // A write fall while nRD is also low is a bus conflict and is dropped.
        wr_cap      = wr_fall & ~both_low;

`ifdef FT245_RESP_LOOPBACK_EN
        rx_src      = wr_cap;
        rx_src_data = data_io;
`else
        rx_src      = host_push_i;
        rx_src_data = host_data_i;
`endif

        rx_push     = rx_src & ~rx_full;
        rx_pop      = rd_rise & (rd_state == RD_ACTIVE);
        tx_push     = wr_cap & ~tx_full;
        tx_pop      = host_pop_i & ~tx_empty;

        overflow_d  = (rx_src & rx_full) | (wr_cap & tx_full);
        proto_err_d = (rd_fall & rx_empty) | (both_low & (rd_fall | wr_fall));

        rd_drive    = ~bus.nRD_i & ~rx_empty;
    end

    // Read-side state, strobe history, hold counters and registered flags.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rd_state    <= RD_IDLE;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            nrxf_q      <= 1'b1;
            ntxe_q      <= 1'b1;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            rxf_hold    <= '0;
            txe_hold    <= '0;
        end else begin
            nrd_q       <= bus.nRD_i;
            nwr_q       <= bus.nWR_i;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;

            case (rd_state)
                RD_IDLE:   if (rd_fall && !rx_empty) rd_state <= RD_ACTIVE;
                RD_ACTIVE: if (rd_rise) rd_state <= RD_IDLE;
                default:   rd_state <= RD_IDLE;
            endcase

            if (rx_pop)
                rxf_hold <= RHW'(RXF_HOLD);
            else if (rxf_hold != '0)
                rxf_hold <= rxf_hold - 1'b1;

            if (wr_rise)
                txe_hold <= THW'(TXE_HOLD);
            else if (txe_hold != '0)
                txe_hold <= txe_hold - 1'b1;

            nrxf_q <= ~((rx_count != '0) && (rxf_hold == '0) && (rd_state != RD_ACTIVE));
            ntxe_q <= ~((tx_count != CW'(DEPTH)) && (txe_hold == '0));
        end
    end

    // RX FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= rx_src_data;
                rx_wr_ptr         <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // TX FIFO storage and pointers; storage cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                tx_mem[i] <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr] <= data_io;
                tx_wr_ptr         <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    assign data_io      = rd_drive ? rx_mem[rx_rd_ptr] : 'z;

    assign bus.nRXF_o   = nrxf_q;
    assign bus.nTXE_o   = ntxe_q;
    assign host_full_o  = rx_full;
    assign host_empty_o = tx_empty;
    assign host_data_o  = tx_mem[tx_rd_ptr];
    assign rx_count_o   = rx_count;
    assign tx_count_o   = tx_count;
    assign overflow_o   = overflow_q;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Directed self-checking bench for ft245_fifo_responder (DEPTH=16, holds=2).
// Build with FT245_RESP_LOOPBACK_EN defined to exercise the loopback path.
module tb_ft245_fifo_responder;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       host_push_i;
    logic [7:0] host_data_i;
    logic       host_full_o;
    logic       host_pop_i;
    logic [7:0] host_data_o;
    logic       host_empty_o;
    logic [4:0] rx_count_o;
    logic [4:0] tx_count_o;
    logic       overflow_o;
    logic       proto_err_o;

    logic       tb_drv;
    logic [7:0] tb_dat;
    wire  [7:0] data_bus;

    int checks = 0;
    int errors = 0;

    ft245_fifo_responder_if bus ();

    assign data_bus = tb_drv ? tb_dat : 'z;

    ft245_fifo_responder #(
        .DEPTH    (16),
        .RXF_HOLD (2),
        .TXE_HOLD (2)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .bus          (bus.slave),
        .data_io      (data_bus),
        .host_push_i  (host_push_i),
        .host_data_i  (host_data_i),
        .host_full_o  (host_full_o),
        .host_pop_i   (host_pop_i),
        .host_data_o  (host_data_o),
        .host_empty_o (host_empty_o),
        .rx_count_o   (rx_count_o),
        .tx_count_o   (tx_count_o),
        .overflow_o   (overflow_o),
        .proto_err_o  (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_rxf();
        int n = 0;
        while (bus.nRXF_o !== 1'b0 && n < 32) begin
            cyc();
            n++;
        end
        check("rxf_wait", bus.nRXF_o, 0);
    endtask

    task automatic wait_txe();
        int n = 0;
        while (bus.nTXE_o !== 1'b0 && n < 32) begin
            cyc();
            n++;
        end
        check("txe_wait", bus.nTXE_o, 0);
    endtask

    task automatic master_read(output logic [7:0] d);
        wait_rxf();
        bus.nRD_i = 1'b0;
        #1;
        d = data_bus;
        cyc();
        bus.nRD_i = 1'b1;
        cyc();
    endtask

    task automatic master_write(input logic [7:0] d);
        wait_txe();
        tb_drv    = 1'b1;
        tb_dat    = d;
        bus.nWR_i = 1'b0;
        cyc();
        bus.nWR_i = 1'b1;
        tb_drv    = 1'b0;
        cyc();
    endtask

    task automatic host_push(input logic [7:0] d);
        host_data_i = d;
        host_push_i = 1'b1;
        cyc();
        host_push_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;

        reset_ni    = 1'b0;
        bus.nRD_i   = 1'b1;
        bus.nWR_i   = 1'b1;
        host_push_i = 1'b0;
        host_data_i = '0;
        host_pop_i  = 1'b0;
        tb_drv      = 1'b0;
        tb_dat      = '0;
        repeat (3) cyc();

        check("rst_nrxf", bus.nRXF_o, 1);
        check("rst_ntxe", bus.nTXE_o, 1);
        check("rst_full", host_full_o, 0);
        check("rst_empty", host_empty_o, 1);
        check("rst_hdata", host_data_o, 0);
        check("rst_rxcnt", rx_count_o, 0);
        check("rst_txcnt", tx_count_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_perr", proto_err_o, 0);

        reset_ni = 1'b1;
        cyc();
        check("ntxe_after_rst", bus.nTXE_o, 0);

`ifdef FT245_RESP_LOOPBACK_EN
        // Loopback: written bytes come back on the read side.
        master_write(8'h11);
        master_write(8'h22);
        check("lb_rxcnt", rx_count_o, 2);
        check("lb_txcnt", tx_count_o, 2);
        master_read(d);
        check("lb_rd0", d, 8'h11);
        master_read(d);
        check("lb_rd1", d, 8'h22);
        check("lb_rxcnt0", rx_count_o, 0);
        check("lb_txcnt_keep", tx_count_o, 2);
        check("lb_hdata", host_data_o, 8'h11);
        repeat (2) begin
            host_pop_i = 1'b1;
            cyc();
        end
        host_pop_i = 1'b0;
        check("lb_tx_drained", tx_count_o, 0);
`else
        // Single read: latency of nRXF, combinational data, hold after pop.
        host_push(8'hA5);
        check("rx_cnt_push", rx_count_o, 1);
        check("rxf_latency", bus.nRXF_o, 1);
        cyc();
        check("rxf_low", bus.nRXF_o, 0);
        bus.nRD_i = 1'b0;
        #1;
        check("rd_data_a5", data_bus, 8'hA5);
        cyc();
        cyc();
        check("rxf_busy", bus.nRXF_o, 1);
        bus.nRD_i   = 1'b1;
        host_data_i = 8'h5A;
        host_push_i = 1'b1;
        cyc();
        host_push_i = 1'b0;
        check("rx_cnt_pushpop", rx_count_o, 1);
        cyc();
        check("rxf_hold1", bus.nRXF_o, 1);
        cyc();
        check("rxf_hold2", bus.nRXF_o, 1);
        cyc();
        check("rxf_release", bus.nRXF_o, 0);
        master_read(d);
        check("rd_data_5a", d, 8'h5A);
        check("rx_cnt_0", rx_count_o, 0);

        // Single write: capture, FWFT head, TXE hold after rise.
        check("ntxe_idle", bus.nTXE_o, 0);
        tb_drv    = 1'b1;
        tb_dat    = 8'h3C;
        bus.nWR_i = 1'b0;
        cyc();
        check("tx_cnt_1", tx_count_o, 1);
        check("hdata_3c", host_data_o, 8'h3C);
        check("hempty_0", host_empty_o, 0);
        bus.nWR_i = 1'b1;
        tb_drv    = 1'b0;
        cyc();
        cyc();
        check("txe_hold1", bus.nTXE_o, 1);
        cyc();
        check("txe_hold2", bus.nTXE_o, 1);
        cyc();
        check("txe_release", bus.nTXE_o, 0);
        host_pop_i = 1'b1;
        cyc();
        check("tx_pop_cnt", tx_count_o, 0);
        check("tx_pop_empty", host_empty_o, 1);
        cyc();
        host_pop_i = 1'b0;
        check("tx_pop_on_empty", tx_count_o, 0);

        // Fill RX past full, then drain across the pointer wrap.
        for (int i = 0; i < 17; i++) begin
            host_push(8'(i));
            if (i == 15) begin
                check("full_at_16", host_full_o, 1);
                check("no_ovf_at_16", overflow_o, 0);
            end
        end
        check("ovf_17th", overflow_o, 1);
        check("rx_cnt_sat", rx_count_o, 16);
        cyc();
        check("ovf_one_pulse", overflow_o, 0);
        for (int i = 0; i < 16; i++) begin
            master_read(d);
            check("rx_order", d, 32'(i));
        end
        check("rx_drained", rx_count_o, 0);
        check("not_full", host_full_o, 0);

        // Fill TX, overflow on the 17th write, free space with a host pop.
        for (int i = 0; i < 16; i++)
            master_write(8'h80 + 8'(i));
        check("tx_cnt_16", tx_count_o, 16);
        cyc();
        check("ntxe_full", bus.nTXE_o, 1);
        tb_drv    = 1'b1;
        tb_dat    = 8'hEE;
        bus.nWR_i = 1'b0;
        cyc();
        check("tx_ovf", overflow_o, 1);
        check("tx_cnt_sat", tx_count_o, 16);
        bus.nWR_i = 1'b1;
        tb_drv    = 1'b0;
        host_pop_i = 1'b1;
        cyc();
        host_pop_i = 1'b0;
        check("tx_ovf_pulse", overflow_o, 0);
        check("tx_cnt_15", tx_count_o, 15);
        check("ntxe_still_high", bus.nTXE_o, 1);
        check("hdata_81", host_data_o, 8'h81);
        wait_txe();
        for (int i = 1; i < 16; i++) begin
            check("tx_order", host_data_o, 32'h80 + 32'(i));
            host_pop_i = 1'b1;
            cyc();
        end
        host_pop_i = 1'b0;
        check("tx_drained", host_empty_o, 1);

        // nRD and nWR falling together with 0x55 waiting in RX.
        host_push(8'h55);
        wait_rxf();
        bus.nRD_i = 1'b0;
        bus.nWR_i = 1'b0;
        cyc();
        check("perr_pulse", proto_err_o, 1);
        check("perr_tx_cnt", tx_count_o, 0);
        check("perr_rd_data", data_bus, 8'h55);
        bus.nWR_i = 1'b1;
        cyc();
        check("perr_one_pulse", proto_err_o, 0);
        bus.nRD_i = 1'b1;
        cyc();
        check("perr_rx_popped", rx_count_o, 0);
`endif

        // Reset in the middle of a read with data in both FIFOs.
        master_write(8'h33);
`ifndef FT245_RESP_LOOPBACK_EN
        host_push(8'h42);
`endif
        wait_rxf();
        bus.nRD_i = 1'b0;
        cyc();
        reset_ni = 1'b0;
        cyc();
        check("mrst_rxcnt", rx_count_o, 0);
        check("mrst_txcnt", tx_count_o, 0);
        check("mrst_nrxf", bus.nRXF_o, 1);
        check("mrst_ntxe", bus.nTXE_o, 1);
        check("mrst_empty", host_empty_o, 1);
        check("mrst_hdata", host_data_o, 0);
        bus.nRD_i = 1'b1;
        cyc();
        reset_ni = 1'b1;
        cyc();
        check("mrst_ntxe_rel", bus.nTXE_o, 0);
        check("mrst_perr", proto_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
